// File: rtl/aes_input_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_input_loader                                                           |
// | Byte-serial key/plaintext assembler and run sequencer for the AES core.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module aes_input_loader #(
  parameter int size        = 128,
  parameter int HOLD_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            key_load,
  output logic [size-1:0] key,
  output logic [127:0]    plaintext,
  output logic            core_reset,
  output logic            core_enable,
  output logic            key_ok,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_KEY = 3'd1,
    S_LOAD_PT  = 3'd2,
    S_ARM      = 3'd3,
    S_HOLD     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [7:0] c_key_last  = 8'(size / 8 - 1);
  localparam logic [7:0] c_pt_last   = 8'd15;
  localparam logic [7:0] c_hold_last = 8'(HOLD_CYCLES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;
  logic [size-1:0] r_key;
  logic [127:0]    r_pt;
  logic            r_key_ok;
  logic            w_key_done;

  always_comb begin
    in_ready    = (r_state == S_LOAD_KEY) || (r_state == S_LOAD_PT);
    core_reset  = (r_state != S_HOLD) && (r_state != S_DONE);
    core_enable = (r_state == S_HOLD);
    done        = (r_state == S_DONE);
    busy        = (r_state != S_IDLE);
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_key_done  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A key reload wins over starting a block.
        if (key_load)
          w_state_nxt = S_LOAD_KEY;
        else if (in_valid && r_key_ok)
          w_state_nxt = S_LOAD_PT;
      end
      S_LOAD_KEY: begin
        if (in_valid) begin
          if (r_cnt == c_key_last) begin
            w_state_nxt = S_IDLE;
            w_key_done  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      S_LOAD_PT: begin
        if (in_valid) begin
          if (r_cnt == c_pt_last)
            w_state_nxt = S_ARM;
          else
            w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_ARM: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (r_cnt == c_hold_last)
          w_state_nxt = S_DONE;
        else
          w_cnt_nxt = r_cnt + 8'd1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // The shared counter restarts from zero in every new state.
    if (w_state_nxt != r_state)
      w_cnt_nxt = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_key    <= '0;
      r_pt     <= '0;
      r_key_ok <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if ((r_state == S_LOAD_KEY) && in_valid)
        r_key <= {r_key[size-9:0], in_data};
      if ((r_state == S_LOAD_PT) && in_valid)
        r_pt <= {r_pt[119:0], in_data};
      if (w_key_done)
        r_key_ok <= 1'b1;
    end
  end

  assign key       = r_key;
  assign plaintext = r_pt;
  assign key_ok    = r_key_ok;

endmodule
`default_nettype wire

// File: tb/tb_aes_input_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_input_loader                                                        |
// | Vector-table and directed-sequence bench for 128- and 256-bit key builds.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_aes_input_loader;

  localparam int c_h0 = 5;
  localparam int c_h1 = 7;

  // Flag order: {in_ready, busy, core_reset, core_enable, done, key_ok}
  localparam logic [5:0] c_f_idle0 = 6'b001000;
  localparam logic [5:0] c_f_idle1 = 6'b001001;
  localparam logic [5:0] c_f_lkey0 = 6'b111000;
  localparam logic [5:0] c_f_lpt   = 6'b111001;
  localparam logic [5:0] c_f_arm   = 6'b011001;
  localparam logic [5:0] c_f_hold  = 6'b010101;
  localparam logic [5:0] c_f_done  = 6'b010011;

  typedef struct {
    logic       rst;
    logic       kl;
    logic       vld;
    logic [7:0] data;
    logic [5:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic kl  = 1'b0;
  logic vld = 1'b0;
  logic [7:0] data = 8'd0;

  logic         rdy0, crst0, en0, kok0, busy0, done0;
  logic         rdy1, crst1, en1, kok1, busy1, done1;
  logic [127:0] key0, pt0, pt1;
  logic [255:0] key1;
  logic [5:0]   obs;

  int n_vec  = 0;
  int n_miss = 0;

  vec_t tbl [38];

  always #5 clk = ~clk;

  aes_input_loader #(.size(128), .HOLD_CYCLES(c_h0)) dut0 (
    .clk(clk), .reset(rst), .in_data(data), .in_valid(vld & ~sel),
    .in_ready(rdy0), .key_load(kl & ~sel), .key(key0), .plaintext(pt0),
    .core_reset(crst0), .core_enable(en0), .key_ok(kok0), .busy(busy0),
    .done(done0)
  );

  aes_input_loader #(.size(256), .HOLD_CYCLES(c_h1)) dut1 (
    .clk(clk), .reset(rst), .in_data(data), .in_valid(vld & sel),
    .in_ready(rdy1), .key_load(kl & sel), .key(key1), .plaintext(pt1),
    .core_reset(crst1), .core_enable(en1), .key_ok(kok1), .busy(busy1),
    .done(done1)
  );

  assign obs = sel ? {rdy1, busy1, crst1, en1, done1, kok1}
                   : {rdy0, busy0, crst0, en0, done0, kok0};

  function automatic vec_t mk(input logic r, input logic k, input logic v,
                              input logic [7:0] d, input logic [5:0] e);
    vec_t t;
    t.rst = r; t.kl = k; t.vld = v; t.data = d; t.exp = e;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk_f(input string nm, input logic [5:0] exp);
    chk(nm, {250'd0, obs}, {250'd0, exp});
  endtask

  // One plaintext block on the selected DUT, from IDLE back to IDLE.
  task automatic run_block(input logic [127:0] pt, input logic toggle, input int hold);
    int xfers;
    int cyc;
    int n;
    vld  = 1'b1;
    data = pt[127:120];
    step();
    chk_f("enter_load_pt", c_f_lpt);
    xfers = 0;
    cyc   = 0;
    while (xfers < 16 && cyc < 100) begin
      vld  = (toggle && (cyc % 2 != 0)) ? 1'b0 : 1'b1;
      data = pt[127 - 8 * xfers -: 8];
      if (vld) xfers++;
      cyc++;
      step();
      chk_f("pt_load", (xfers < 16) ? c_f_lpt : c_f_arm);
    end
    vld = 1'b0;
    chk("arm_cycle", 256'(cyc), toggle ? 256'd31 : 256'd16);
    chk("plaintext", sel ? {128'd0, pt1} : {128'd0, pt0}, {128'd0, pt});
    step();
    chk_f("hold_entry", c_f_hold);
    n = 0;
    while (obs[2] && n < 300) begin
      n++;
      step();
    end
    chk("enable_len", 256'(n), 256'(hold));
    chk_f("done_pulse", c_f_done);
    step();
    chk_f("back_idle", c_f_idle1);
  endtask

  initial begin
    tbl[0] = mk(1'b1, 1'b0, 1'b0, 8'h00, c_f_idle0);
    for (int i = 1; i <= 20; i++)
      tbl[i] = mk(1'b0, 1'b0, 1'b1, 8'h5a, c_f_idle0);
    tbl[21] = mk(1'b0, 1'b1, 1'b1, 8'haa, c_f_lkey0);
    for (int i = 0; i < 16; i++)
      tbl[22 + i] = mk(1'b0, 1'b0, 1'b1, 8'(i), (i < 15) ? c_f_lkey0 : c_f_idle1);

    step();
    for (int i = 0; i < 38; i++) begin
      rst  = tbl[i].rst;
      kl   = tbl[i].kl;
      vld  = tbl[i].vld;
      data = tbl[i].data;
      step();
      chk_f($sformatf("vec%0d", i), tbl[i].exp);
    end
    vld = 1'b0;
    chk("key128", {128'd0, key0}, {128'd0, 128'h000102030405060708090a0b0c0d0e0f});

    run_block(128'h00112233445566778899aabbccddeeff, 1'b0, c_h0);
    run_block(128'hf0e1d2c3b4a5968778695a4b3c2d1e0f, 1'b1, c_h0);
    chk("key_retained", {128'd0, key0}, {128'd0, 128'h000102030405060708090a0b0c0d0e0f});

    // Reset while the core is running.
    vld = 1'b1;
    step();
    for (int i = 0; i < 16; i++) step();
    vld = 1'b0;
    step();
    step();
    chk_f("in_hold", c_f_hold);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_f("reset_in_hold", c_f_idle0);
    chk("key_cleared", {128'd0, key0}, 256'd0);
    chk("pt_cleared", {128'd0, pt0}, 256'd0);
    vld = 1'b1;
    for (int i = 0; i < 5; i++) step();
    vld = 1'b0;
    chk_f("no_key_idle", c_f_idle0);

    // 256-bit key build.
    sel  = 1'b1;
    kl   = 1'b1;
    vld  = 1'b1;
    data = 8'haa;
    step();
    chk_f("lkey256", c_f_lkey0);
    kl = 1'b0;
    for (int i = 0; i < 32; i++) begin
      data = 8'(i);
      step();
    end
    vld = 1'b0;
    chk_f("key256_ok", c_f_idle1);
    chk("key256", key1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    run_block(128'h00112233445566778899aabbccddeeff, 1'b0, c_h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
